// File: rtl/reg_chain_arbiter.sv
// reg_chain_arbiter: round-robin sharing of a two-stage clock-enabled
// register chain between requesters A and B, with valid/owner tracking,
// downstream backpressure and per-requester completion counters.
module reg_chain_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] Din_a,
  input  logic             req_a,
  output logic             gnt_a,
  input  logic [WIDTH-1:0] Din_b,
  input  logic             req_b,
  output logic             gnt_b,
  input  logic             flush,
  output logic             Ce,
  output logic [WIDTH-1:0] Dout,
  output logic             Dout_valid,
  output logic             Dout_tag,
  input  logic             Dout_ready,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  logic [WIDTH-1:0] d0, d1;
  logic             v0, v1;
  logic             t0, t1;
  logic             ptr;
  logic             consume;
  logic [WIDTH-1:0] din_sel;

  // Chain advances when the output stage is empty or being drained, never during flush
  assign Ce         = (~v1 | Dout_ready) & ~flush;
  assign Dout       = d1;
  assign Dout_valid = v1;
  assign Dout_tag   = t1;
  assign occupancy  = {1'b0, v0} + {1'b0, v1};
  assign consume    = v1 & Dout_ready;

  // Round-robin grant; ptr selects the winner only when both request
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (Ce && !RST) begin
      if (req_a && req_b) begin
        gnt_a = ~ptr;
        gnt_b = ptr;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  assign din_sel = gnt_b ? Din_b : Din_a;

  // Chain stages, priority pointer and completion counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      d0    <= '0;
      d1    <= '0;
      v0    <= 1'b0;
      v1    <= 1'b0;
      t0    <= 1'b0;
      t1    <= 1'b0;
      ptr   <= 1'b0;
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      // A consume still counts in a flush cycle
      if (consume) begin
        if (t1) cnt_b <= cnt_b + CNT_W'(1);
        else    cnt_a <= cnt_a + CNT_W'(1);
      end
      if (flush) begin
        v0 <= 1'b0;
        v1 <= 1'b0;
      end else if (Ce) begin
        d1 <= d0;
        v1 <= v0;
        t1 <= t0;
        v0 <= gnt_a | gnt_b;
        if (gnt_a || gnt_b) begin
          d0 <= din_sel;
          t0 <= gnt_b;
        end
      end
      if (gnt_a || gnt_b) ptr <= gnt_a;
    end
  end

endmodule

// File: tb/tb_reg_chain_arbiter.sv
// Directed bench for reg_chain_arbiter with a slot-list reference model
// checked every cycle, plus literal expectations per scenario.
module tb_reg_chain_arbiter;
  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  logic             CLK = 1'b0;
  logic             RST;
  logic [WIDTH-1:0] Din_a, Din_b;
  logic             req_a, req_b, gnt_a, gnt_b;
  logic             flush, Ce, Dout_valid, Dout_tag, Dout_ready;
  logic [WIDTH-1:0] Dout;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  int vectors = 0;
  int miscompares = 0;
  logic check_en = 1'b0;
  int cyc = 0;

  reg_chain_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .Din_a(Din_a), .req_a(req_a), .gnt_a(gnt_a),
    .Din_b(Din_b), .req_b(req_b), .gnt_b(gnt_b),
    .flush(flush), .Ce(Ce),
    .Dout(Dout), .Dout_valid(Dout_valid), .Dout_tag(Dout_tag),
    .Dout_ready(Dout_ready), .occupancy(occupancy),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  always #5 CLK = ~CLK;

  // Reference model: two slots, index 0 = entry, index 1 = output
  typedef struct { bit v; bit [WIDTH-1:0] d; bit t; } slot_t;
  slot_t chain [2];
  bit    m_ptr;
  int    m_ca, m_cb;

  function automatic bit m_ce();
    return (!chain[1].v || Dout_ready) && !flush;
  endfunction

  // Returns {grant_b, grant_a}
  function automatic bit [1:0] m_gnt();
    if (RST || !m_ce()) return 2'b00;
    if (req_a && req_b) return m_ptr ? 2'b10 : 2'b01;
    return {req_b, req_a};
  endfunction

  slot_t    n0, n1;
  bit [1:0] g;
  bit       np;
  int       nca, ncb;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    g = m_gnt();
    n0 = chain[0]; n1 = chain[1]; np = m_ptr; nca = m_ca; ncb = m_cb;
    if (RST) begin
      n0 = '{0, 0, 0}; n1 = '{0, 0, 0}; np = 0; nca = 0; ncb = 0;
    end else begin
      if (chain[1].v && Dout_ready) begin
        if (chain[1].t) ncb = (m_cb + 1) % (1 << CNT_W);
        else            nca = (m_ca + 1) % (1 << CNT_W);
      end
      if (flush) begin
        n0.v = 0; n1.v = 0;
      end else if (m_ce()) begin
        n1 = chain[0];
        if (g != 2'b00) n0 = '{1, (g[1] ? Din_b : Din_a), g[1]};
        else            n0.v = 0;
      end
      if (g != 2'b00) np = g[0];
    end
    chain[0] <= n0; chain[1] <= n1; m_ptr <= np; m_ca <= nca; m_cb <= ncb;
  end

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge CLK) begin
    if (check_en) begin
      cmp("m_ce", Ce, m_ce());
      cmp("m_gnt_a", gnt_a, m_gnt()[0]);
      cmp("m_gnt_b", gnt_b, m_gnt()[1]);
      cmp("m_valid", Dout_valid, chain[1].v);
      if (chain[1].v) begin
        cmp("m_dout", Dout, chain[1].d);
        cmp("m_tag", Dout_tag, chain[1].t);
      end
      cmp("m_occ", occupancy, chain[0].v + chain[1].v);
      cmp("m_cnt_a", cnt_a, m_ca);
      cmp("m_cnt_b", cnt_b, m_cb);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic lit(input string name, input int act, input int exp);
    cmp(name, act, exp);
  endtask

  task automatic do_reset();
    RST = 1; req_a = 0; req_b = 0; flush = 0; Dout_ready = 0;
    Din_a = '0; Din_b = '0;
    tick();
    check_en = 1'b1;
    tick();
    RST = 0;
  endtask

  initial begin
    RST = 1; req_a = 0; req_b = 0; flush = 0; Dout_ready = 0;
    Din_a = '0; Din_b = '0;

    // Reset then idle
    do_reset();
    @(negedge CLK);
    lit("rst_valid", Dout_valid, 0);
    lit("rst_occ", occupancy, 0);
    lit("rst_ce", Ce, 1);
    lit("rst_cnt_a", cnt_a, 0);
    lit("rst_cnt_b", cnt_b, 0);
    lit("rst_dout", Dout, 0);
    lit("rst_tag", Dout_tag, 0);
    lit("rst_gnt", {gnt_b, gnt_a}, 0);

    // Single A stream: 3, 5, 9
    do_reset();
    Dout_ready = 1; req_a = 1; Din_a = 4'd3;
    @(negedge CLK); lit("a_gnt0", gnt_a, 1);
    tick(); Din_a = 4'd5;
    @(negedge CLK); lit("a_valid1", Dout_valid, 0);
    tick(); Din_a = 4'd9;
    @(negedge CLK); lit("a_dout3", Dout, 3); lit("a_valid2", Dout_valid, 1);
    tick(); req_a = 0;
    @(negedge CLK); lit("a_dout5", Dout, 5); lit("a_tag", Dout_tag, 0);
    tick();
    @(negedge CLK); lit("a_dout9", Dout, 9);
    tick();
    @(negedge CLK); lit("a_cnt", cnt_a, 3); lit("a_valid_end", Dout_valid, 0);

    // Contention: alternate A, B, A, B
    do_reset();
    Dout_ready = 1; req_a = 1; req_b = 1; Din_a = 4'hA; Din_b = 4'hB;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge CLK);
      lit("c_gnt_a", gnt_a, (i % 2 == 0) ? 1 : 0);
      lit("c_gnt_b", gnt_b, (i % 2 == 1) ? 1 : 0);
      tick();
    end
    req_a = 0; req_b = 0;
    for (int unsigned i = 0; i < 2; i++) begin
      @(negedge CLK);
      lit("c_dout", Dout, (i % 2 == 0) ? 4'hA : 4'hB);
      tick();
    end
    tick();
    @(negedge CLK); lit("c_cnt_a", cnt_a, 2); lit("c_cnt_b", cnt_b, 2);

    // Backpressure: fill A=1, B=2, stall 3 cycles
    do_reset();
    Dout_ready = 1; req_a = 1; Din_a = 4'd1;
    tick(); req_a = 0; req_b = 1; Din_b = 4'd2;
    @(negedge CLK); lit("bp_gnt_b", gnt_b, 1);
    tick(); req_b = 0; req_a = 1; Dout_ready = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge CLK);
      lit("bp_ce", Ce, 0);
      lit("bp_gnt", {gnt_b, gnt_a}, 0);
      lit("bp_dout", Dout, 1);
      lit("bp_occ", occupancy, 2);
      tick();
    end
    req_a = 0; Dout_ready = 1;
    @(negedge CLK); lit("bp_rel1", Dout, 1);
    tick();
    @(negedge CLK); lit("bp_rel2", Dout, 2); lit("bp_tag2", Dout_tag, 1);
    tick();

    // Flush mid-stream with ptr=1
    do_reset();
    req_b = 1; Din_b = 4'd6;
    tick(); req_b = 0; req_a = 1; Din_a = 4'd4;
    tick();
    flush = 1;
    @(negedge CLK); lit("fl_occ", occupancy, 2); lit("fl_gnt_a", gnt_a, 0);
    tick(); flush = 0; req_b = 1; Dout_ready = 1;
    @(negedge CLK);
    lit("fl_occ0", occupancy, 0); lit("fl_valid", Dout_valid, 0);
    lit("fl_ptr_b", gnt_b, 1); lit("fl_ptr_a", gnt_a, 0);
    tick(); req_a = 0; req_b = 0;
    tick(); tick();

    // Counter wrap (CNT_W=2) and reset mid-stream
    do_reset();
    Dout_ready = 1; req_a = 1;
    for (int unsigned i = 0; i < 5; i++) begin
      Din_a = WIDTH'(i + 1);
      tick();
    end
    req_a = 0;
    tick(); tick();
    @(negedge CLK); lit("w_cnt_a", cnt_a, 1); lit("w_valid", Dout_valid, 0);
    Dout_ready = 0; req_a = 1; Din_a = 4'd7;
    tick(); Din_a = 4'd8;
    tick(); req_a = 0;
    @(negedge CLK); lit("w_occ", occupancy, 2);
    RST = 1;
    tick(); RST = 0;
    @(negedge CLK);
    lit("w_rst_occ", occupancy, 0); lit("w_rst_valid", Dout_valid, 0);
    lit("w_rst_cnt", cnt_a, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
